// File: rtl/wb_arb_pkg.sv
// Shared types for the regfile write-port arbiter: arbitration state and write request payload.
package wb_arb_pkg;

  typedef enum logic {S_PIPE, S_FORCE} wb_arb_state_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  localparam int unsigned STARVE_MAX_DEF = 4;

  // x0 writes are architecturally discarded, so they never need the port.
  function automatic logic rd_live(input logic [4:0] rd);
    return rd != 5'd0;
  endfunction

endpackage

// File: rtl/wb_arb_perf.sv
// Free-running conflict / forced-grant event counters for the write-port arbiter.
// Present only when WB_ARB_PERF_EN is defined.
`ifdef WB_ARB_PERF_EN
module wb_arb_perf (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_conflict,
  input  logic        i_forced,
  output logic [31:0] o_conflicts,
  output logic [31:0] o_forced
);

  logic [31:0] r_conflicts;
  logic [31:0] r_forced;

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_conflicts <= '0;
      r_forced    <= '0;
    end else begin
      if (i_conflict) r_conflicts <= r_conflicts + 32'd1;
      if (i_forced)   r_forced    <= r_forced + 32'd1;
    end
  end

  assign o_conflicts = r_conflicts;
  assign o_forced    = r_forced;

endmodule
`endif

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single regfile write port between in-order writeback and the MDU result.
// Optional perf counters are enabled with WB_ARB_PERF_EN.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic        wb_exc,
  input  logic [29:0] wb_pc,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  output logic        wb_stall,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_reg,
  input  logic [31:0] mdu_data,
  output logic        mdu_ready,
  output logic [4:0]  wreg,
  output logic [31:0] wdata,
  output logic        wen
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0] perf_conflicts,
  output logic [31:0] perf_forced
`endif
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  wb_arb_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_starve_cnt, w_cnt_nxt;
  logic          w_pipe_req, w_mdu_req, w_mdu_drop;
  logic          w_grant_pipe, w_grant_mdu, w_forced;
  wb_req_t       w_pipe, w_mdu, w_sel;
  logic          w_unused_pc;

  assign w_unused_pc = ^wb_pc;

  assign w_pipe_req = wb_valid & ~wb_exc & rd_live(wb_reg);
  assign w_mdu_req  = mdu_valid & rd_live(mdu_reg);
  assign w_mdu_drop = mdu_valid & ~rd_live(mdu_reg);
  assign w_pipe     = '{rd: wb_reg, data: wb_data};
  assign w_mdu      = '{rd: mdu_reg, data: mdu_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_PIPE;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_cnt_nxt;
    end
  end

  // Grant and write-port mux; reset blocks every grant so nothing is written.
  always_comb begin
    w_grant_pipe = 1'b0;
    w_grant_mdu  = 1'b0;
    w_forced     = 1'b0;
    mdu_ready    = 1'b0;
    if (!reset) begin
      if (r_state == S_FORCE && w_mdu_req) begin
        w_grant_mdu = 1'b1;
        w_forced    = 1'b1;
      end else if (w_pipe_req) begin
        w_grant_pipe = 1'b1;
      end else if (w_mdu_req) begin
        w_grant_mdu = 1'b1;
      end
      mdu_ready = w_grant_mdu | w_mdu_drop;
    end
    w_sel    = w_grant_mdu ? w_mdu : w_pipe;
    wen      = w_grant_pipe | w_grant_mdu;
    wreg     = w_sel.rd;
    wdata    = w_sel.data;
    wb_stall = w_forced & w_pipe_req;
  end

  // S_FORCE lasts exactly one cycle, so each starvation episode gets one forced grant.
  always_comb begin
    w_cnt_nxt   = r_starve_cnt;
    w_state_nxt = S_PIPE;
    if (mdu_ready)
      w_cnt_nxt = '0;
    else if (w_mdu_req && r_starve_cnt != CNT_MAX)
      w_cnt_nxt = r_starve_cnt + 1'b1;
    if (r_state == S_PIPE && w_cnt_nxt == CNT_MAX)
      w_state_nxt = S_FORCE;
  end

`ifdef WB_ARB_PERF_EN
  wb_arb_perf u_perf (
    .clk         (clk),
    .reset       (reset),
    .i_conflict  (w_pipe_req & w_mdu_req),
    .i_forced    (w_forced),
    .o_conflicts (perf_conflicts),
    .o_forced    (perf_forced)
  );
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed vectors push expectations, a negedge monitor checks them.
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_valid = 1'b0, wb_exc = 1'b0;
  logic [29:0] wb_pc = '0;
  logic [4:0]  wb_reg = '0;
  logic [31:0] wb_data = '0;
  logic        wb_stall;
  logic        mdu_valid = 1'b0;
  logic [4:0]  mdu_reg = '0;
  logic [31:0] mdu_data = '0;
  logic        mdu_ready;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic        wen;
`ifdef WB_ARB_PERF_EN
  logic [31:0] perf_conflicts, perf_forced;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        wen;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        stall;
    logic        ready;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  wb_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .wb_valid  (wb_valid),
    .wb_exc    (wb_exc),
    .wb_pc     (wb_pc),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .wb_stall  (wb_stall),
    .mdu_valid (mdu_valid),
    .mdu_reg   (mdu_reg),
    .mdu_data  (mdu_data),
    .mdu_ready (mdu_ready),
    .wreg      (wreg),
    .wdata     (wdata),
    .wen       (wen)
`ifdef WB_ARB_PERF_EN
    ,
    .perf_conflicts (perf_conflicts),
    .perf_forced    (perf_forced)
`endif
  );

  task automatic vec(input string nm, input logic rst_i,
                     input logic wv, input logic we, input logic [4:0] wr, input logic [31:0] wd,
                     input logic mv, input logic [4:0] mr, input logic [31:0] md,
                     input logic e_wen, input logic [4:0] e_wreg, input logic [31:0] e_wdata,
                     input logic e_stall, input logic e_ready);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst_i;
    wb_valid  = wv;
    wb_exc    = we;
    wb_reg    = wr;
    wb_data   = wd;
    wb_pc     = wb_pc + 30'd1;
    mdu_valid = mv;
    mdu_reg   = mr;
    mdu_data  = md;
    e.name  = nm;
    e.wen   = e_wen;
    e.wreg  = e_wreg;
    e.wdata = e_wdata;
    e.stall = e_stall;
    e.ready = e_ready;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if (wen !== e.wen || wb_stall !== e.stall || mdu_ready !== e.ready ||
          (e.wen && (wreg !== e.wreg || wdata !== e.wdata))) begin
        errors++;
        $display("FAIL %s: got wen=%0b wreg=%0d wdata=%h stall=%0b ready=%0b, want wen=%0b wreg=%0d wdata=%h stall=%0b ready=%0b",
                 e.name, wen, wreg, wdata, wb_stall, mdu_ready,
                 e.wen, e.wreg, e.wdata, e.stall, e.ready);
      end
    end
  end

  initial begin
    int guard;
    // reset holds wen low
    vec("reset", 1, 1,0,5,32'h1234, 0,0,32'h0, 0,5,32'h1234, 0,0);
    // pipeline only
    vec("pipe", 0, 1,0,5,32'hDEADBEEF, 0,0,32'h0, 1,5,32'hDEADBEEF, 0,0);
    // faulted insn leaves port to MDU
    vec("exc_mdu", 0, 1,1,5,32'h1111, 1,7,32'h7777, 1,7,32'h7777, 0,1);
    vec("x0_idle", 0, 1,0,0,32'h2222, 0,0,32'h0, 0,0,32'h2222, 0,0);
    vec("x0_mdu", 0, 1,0,0,32'h2222, 1,7,32'h77, 1,7,32'h77, 0,1);
    // MDU to x0 is dropped immediately, pipe still writes
    vec("mdu_x0", 0, 1,0,3,32'h33, 1,0,32'h55, 1,3,32'h33, 0,1);
    // contention: 4 refusals then forced grant with stall
    for (int i = 0; i < 4; i++)
      vec("starve", 0, 1,0,5'(1+i),32'hA0+i, 1,9,32'h99, 1,5'(1+i),32'hA0+i, 0,0);
    vec("force", 0, 1,0,5,32'hA4, 1,9,32'h99, 1,9,32'h99, 1,1);
    vec("resume", 0, 1,0,2,32'hB, 0,0,32'h0, 1,2,32'hB, 0,0);
`ifdef WB_ARB_PERF_EN
    checks++;
    if (perf_conflicts !== 32'd5 || perf_forced !== 32'd1) begin
      errors++;
      $display("FAIL perf: got conflicts=%0d forced=%0d, want 5 and 1", perf_conflicts, perf_forced);
    end
`endif
    // idle gap grants MDU without stall and clears the count
    vec("gap_ref", 0, 1,0,3,32'hC0, 1,10,32'hAA, 1,3,32'hC0, 0,0);
    vec("gap_ref", 0, 1,0,3,32'hC0, 1,10,32'hAA, 1,3,32'hC0, 0,0);
    vec("gap_grant", 0, 0,0,3,32'hC1, 1,10,32'hAA, 1,10,32'hAA, 0,1);
    for (int i = 0; i < 4; i++)
      vec("clr_ref", 0, 1,0,4,32'hD0+i, 1,11,32'hBB, 1,4,32'hD0+i, 0,0);
    vec("clr_force", 0, 1,0,4,32'hD4, 1,11,32'hBB, 1,11,32'hBB, 1,1);
    // reset while in S_FORCE
    for (int i = 0; i < 4; i++)
      vec("pre_rst", 0, 1,0,6,32'hE0+i, 1,12,32'hCC, 1,6,32'hE0+i, 0,0);
    vec("rst_force", 1, 1,0,6,32'hE4, 1,12,32'hCC, 0,6,32'hE4, 0,0);
    for (int i = 0; i < 4; i++)
      vec("post_rst", 0, 1,0,6,32'hE5+i, 1,12,32'hCC, 1,6,32'hE5+i, 0,0);
    // faulted pipe insn in the forced cycle is not stalled
    vec("force_exc", 0, 1,1,6,32'hE9, 1,12,32'hCC, 1,12,32'hCC, 0,1);
    vec("idle", 0, 0,0,0,32'h0, 0,0,32'h0, 0,0,32'h0, 0,0);

    guard = 0;
    while (sb_q.size() > 0 && guard < 20) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
